// File: rtl/mem_port_arbiter.sv
// Two-requester front end for the single AXI4-Lite master port of nano_rv32i.
// Fetch (read-only) and load/store are round-robin arbitrated; one transaction is in flight at a time.
module mem_port_arbiter #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [STRB_W-1:0] ls_wstrb_i,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_ready_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_last_grant;   // 1'b0 = fetch, 1'b1 = load/store
    logic                r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ls_rdata;
    logic                r_if_ready;
    logic                r_ls_ready;
    logic                r_err;

    logic                w_any_req;
    logic                w_grant_ls;
    logic                w_aw_ok;
    logic                w_w_ok;

    // On a tie the requester that did not win last time is served.
    assign w_any_req  = if_req_i | ls_req_i;
    assign w_grant_ls = ls_req_i & (~if_req_i | ~r_last_grant);
    assign w_aw_ok    = ~r_awvalid | m_axi_awready;
    assign w_w_ok     = ~r_wvalid  | m_axi_wready;

    // Arbitration and AXI sequencing FSM; every output comes straight from a register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_wstrb      <= {STRB_W{1'b0}};
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_if_rdata   <= {DATA_W{1'b0}};
            r_ls_rdata   <= {DATA_W{1'b0}};
            r_if_ready   <= 1'b0;
            r_ls_ready   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_ls_ready <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_id         <= w_grant_ls;
                        r_last_grant <= w_grant_ls;
                        r_addr       <= w_grant_ls ? ls_addr_i : if_addr_i;
                        r_wdata      <= ls_wdata_i;
                        r_wstrb      <= ls_wstrb_i;
                        if (w_grant_ls && ls_we_i) begin
                            r_state   <= S_WR_ADDR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_RD_ADDR;
                            r_arvalid <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_ADDR: begin
                    // AW and W retire independently, in either order.
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_state  <= S_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready   <= 1'b0;
                        r_err      <= (m_axi_bresp != 2'b00);
                        r_if_ready <= ~r_id;
                        r_ls_ready <= r_id;
                        r_state    <= S_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rready <= 1'b0;
                        if (r_id) begin
                            r_ls_rdata <= m_axi_rdata;
                        end else begin
                            r_if_rdata <= m_axi_rdata;
                        end
                        r_err      <= (m_axi_rresp != 2'b00);
                        r_if_ready <= ~r_id;
                        r_ls_ready <= r_id;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o    = r_if_rdata;
    assign if_ready_o    = r_if_ready;
    assign ls_rdata_o    = r_ls_rdata;
    assign ls_ready_o    = r_ls_ready;
    assign err_o         = r_err;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bench-side slave tasks serve AXI, a queue of
// expected transactions is pushed at stimulus time and popped when a ready pulse appears.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        ls_req_i;
    logic        ls_we_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic [3:0]  ls_wstrb_i;
    logic [31:0] ls_rdata_o;
    logic        ls_ready_o;
    logic        err_o;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
        .ls_wstrb_i(ls_wstrb_i), .ls_rdata_o(ls_rdata_o), .ls_ready_o(ls_ready_o), .err_o(err_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        id;     // 0 = fetch, 1 = load/store
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;   // read data returned by the slave, or store data
        logic [3:0]  strb;
        logic [1:0]  resp;
    } txn_t;

    txn_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish within 300000 time units");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic txn_t mk(input logic id, input logic we, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp);
        txn_t t;
        t.id = id; t.we = we; t.addr = addr; t.data = data; t.strb = strb; t.resp = resp;
        return t;
    endfunction

    task automatic all_outputs_zero(input string tag);
        chk(tag, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                  if_ready_o, ls_ready_o, err_o, m_axi_araddr, if_rdata_o, ls_rdata_o}, 128'd0);
    endtask

    task automatic wait_arvalid();
        int n = 0;
        while (m_axi_arvalid !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("arvalid_seen", m_axi_arvalid, 1'b1);
    endtask

    // Serves the read at the queue head; returns on the negedge where ready should be high.
    task automatic read_slave(input int ar_wait);
        txn_t t = exp_q[0];
        wait_arvalid();
        chk("araddr", m_axi_araddr, t.addr);
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk_i);
            chk("ar_stall", {m_axi_arvalid, m_axi_araddr, if_ready_o, ls_ready_o},
                {1'b1, t.addr, 1'b0, 1'b0});
        end
        m_axi_arready = 1'b1;
        @(negedge clk_i);
        m_axi_arready = 1'b0;
        chk("ar_done", {m_axi_arvalid, m_axi_rready}, 2'b01);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = t.data;
        m_axi_rresp  = t.resp;
        @(negedge clk_i);
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = 32'h0BAD_0BAD;
        m_axi_rresp  = 2'b00;
    endtask

    // Serves the write at the queue head with independent AW/W ready delays.
    task automatic write_slave(input int aw_wait, input int w_wait);
        txn_t t = exp_q[0];
        bit   aw_done = 1'b0;
        bit   w_done  = 1'b0;
        int   c = 0;
        int   n = 0;
        while (m_axi_awvalid !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("aw_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, {t.addr, t.data, t.strb});
        while (!(aw_done && w_done) && c < 40) begin
            chk("aw_w_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata},
                {!aw_done, !w_done, t.addr, t.data});
            m_axi_awready = !aw_done && (c >= aw_wait);
            m_axi_wready  = !w_done  && (c >= w_wait);
            @(negedge clk_i);
            if (m_axi_awready) aw_done = 1'b1;
            if (m_axi_wready)  w_done  = 1'b1;
            c++;
        end
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        chk("wr_resp_entry", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = t.resp;
        @(negedge clk_i);
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
    endtask

    // Pops the expected transaction and checks the ready pulse, then that it lasts one cycle.
    task automatic check_ready(input bit drop_if, input bit drop_ls);
        txn_t t = exp_q.pop_front();
        chk("ready_pulse", {if_ready_o, ls_ready_o, err_o}, {!t.id, t.id, t.resp != 2'b00});
        if (!t.we) chk("rdata", t.id ? ls_rdata_o : if_rdata_o, t.data);
        if (drop_if) if_req_i = 1'b0;
        if (drop_ls) ls_req_i = 1'b0;
        @(negedge clk_i);
        chk("pulse_end", {if_ready_o, ls_ready_o, err_o}, 3'b000);
        if (!t.we) chk("rdata_hold", t.id ? ls_rdata_o : if_rdata_o, t.data);
    endtask

    initial begin
        int c0;
        rst_n_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = 32'h0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0; ls_wstrb_i = 4'h0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = 32'h0BAD_0BAD; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
        repeat (2) @(negedge clk_i);
        all_outputs_zero("reset_state");
        rst_n_i = 1'b1;
        @(negedge clk_i);
        all_outputs_zero("idle_after_reset");

        // Test 1: single fetch, zero-wait slave; ready in the fourth cycle counting the request cycle.
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'h0, 2'b00));
        if_addr_i = 32'h0000_0100;
        if_req_i  = 1'b1;
        c0 = cyc;
        read_slave(0);
        chk("fetch_latency", cyc - c0, 32'd3);
        check_ready(1'b1, 1'b0);

        // Test 2: store, wready immediately, awready two cycles later.
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 2'b00));
        ls_we_i = 1'b1; ls_addr_i = 32'h0000_0200; ls_wdata_i = 32'h1234_5678; ls_wstrb_i = 4'b0011;
        ls_req_i = 1'b1;
        write_slave(2, 0);
        check_ready(1'b0, 1'b1);

        // Store with both handshakes in the same cycle and an error response.
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_0210, 32'hA5A5_5A5A, 4'b1111, 2'b11));
        ls_addr_i = 32'h0000_0210; ls_wdata_i = 32'hA5A5_5A5A; ls_wstrb_i = 4'b1111;
        ls_req_i = 1'b1;
        write_slave(0, 0);
        check_ready(1'b0, 1'b1);

        // Test 3: both held continuously; last grant was LS so the order is IF, LS, IF, LS.
        ls_we_i = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0300, 32'h1111_0001, 4'h0, 2'b00));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0400, 32'h2222_0002, 4'h0, 2'b00));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0300, 32'h3333_0003, 4'h0, 2'b00));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0400, 32'h4444_0004, 4'h0, 2'b00));
        if_addr_i = 32'h0000_0300; ls_addr_i = 32'h0000_0400;
        if_req_i = 1'b1; ls_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_slave(0);
            check_ready(i == 3, i == 3);
        end

        // Test 4: load with SLVERR.
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0500, 32'hCAFE_F00D, 4'h0, 2'b10));
        ls_addr_i = 32'h0000_0500;
        ls_req_i  = 1'b1;
        read_slave(0);
        check_ready(1'b0, 1'b1);

        // Test 6: arready stalled for 10 cycles.
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0700, 32'h7777_8888, 4'h0, 2'b00));
        if_addr_i = 32'h0000_0700;
        if_req_i  = 1'b1;
        read_slave(10);
        check_ready(1'b1, 1'b0);

        // Test 5: reset while waiting for read data.
        if_addr_i = 32'h0000_0600;
        if_req_i  = 1'b1;
        wait_arvalid();
        m_axi_arready = 1'b1;
        @(negedge clk_i);
        m_axi_arready = 1'b0;
        chk("rd_data_state", {m_axi_arvalid, m_axi_rready}, 2'b01);
        rst_n_i  = 1'b0;
        if_req_i = 1'b0;
        #1;
        all_outputs_zero("async_reset_mid_txn");
        @(negedge clk_i);
        all_outputs_zero("reset_held");
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // After reset the tie goes to fetch first, then load/store.
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0800, 32'h0F0F_1234, 4'h0, 2'b00));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0900, 32'hF0F0_5678, 4'h0, 2'b01));
        if_addr_i = 32'h0000_0800; ls_addr_i = 32'h0000_0900;
        if_req_i = 1'b1; ls_req_i = 1'b1;
        read_slave(0);
        check_ready(1'b1, 1'b0);
        read_slave(0);
        check_ready(1'b0, 1'b1);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
